// File: rtl/ca_spreader.sv
// C/A spreader: XORs navigation data bits onto PN chips.
// Bit edges stay aligned to code epoch boundaries.
//
// state | meaning
// IDLE  | no bit being spread; chips output as 0, wait for a buffered bit at an epoch end
// RUN   | cur_bit spread onto each chip; epoch_cnt counts epochs within the bit
module ca_spreader #(
  parameter int CHIPS_PER_EPOCH = 1023,
  parameter int EPOCHS_PER_BIT  = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic chip_en,
  input  logic code_in,
  input  logic data_in,
  input  logic data_valid,
  output logic data_ready,
  output logic spread_out,
  output logic epoch_pulse,
  output logic bit_pulse,
  output logic underrun
);

  localparam int CW = $clog2(CHIPS_PER_EPOCH);
  localparam logic [CW-1:0] LAST_CHIP  = CW'(CHIPS_PER_EPOCH - 1);
  localparam logic [5:0]    LAST_EPOCH = 6'(EPOCHS_PER_BIT - 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] chip_cnt;
  logic [5:0]    epoch_cnt, epoch_cnt_nxt;
  logic          cur_bit, cur_bit_nxt;
  logic          next_bit, next_bit_nxt;
  logic          next_full, next_full_nxt;
  logic          epoch_end;
  logic          accept;
  logic          bit_end;
  logic          underrun_set;

  assign epoch_end  = chip_en && (chip_cnt == LAST_CHIP);
  assign data_ready = !next_full;
  assign accept     = data_valid && !next_full;

  // Accept needs an empty buffer and load needs a full one, so they never collide.
  always_comb begin
    state_nxt     = state;
    cur_bit_nxt   = cur_bit;
    next_bit_nxt  = next_bit;
    next_full_nxt = next_full;
    epoch_cnt_nxt = epoch_cnt;
    bit_end       = 1'b0;
    underrun_set  = 1'b0;

    if (accept) begin
      next_bit_nxt  = data_in;
      next_full_nxt = 1'b1;
    end

    case (state)
      IDLE: begin
        epoch_cnt_nxt = '0;
        if (epoch_end && next_full) begin
          cur_bit_nxt   = next_bit;
          next_full_nxt = 1'b0;
          state_nxt     = RUN;
        end
      end
      RUN: begin
        if (epoch_end) begin
          if (epoch_cnt < LAST_EPOCH) begin
            epoch_cnt_nxt = epoch_cnt + 6'd1;
          end else begin
            bit_end       = 1'b1;
            epoch_cnt_nxt = '0;
            if (next_full) begin
              cur_bit_nxt   = next_bit;
              next_full_nxt = 1'b0;
            end else begin
              state_nxt    = IDLE;
              underrun_set = 1'b1;
            end
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      epoch_cnt <= '0;
      cur_bit   <= 1'b0;
      next_bit  <= 1'b0;
      next_full <= 1'b0;
    end else begin
      state     <= state_nxt;
      epoch_cnt <= epoch_cnt_nxt;
      cur_bit   <= cur_bit_nxt;
      next_bit  <= next_bit_nxt;
      next_full <= next_full_nxt;
    end
  end

  // Spread chip uses the pre-edge state, so the boundary chip still carries the old bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chip_cnt    <= '0;
      spread_out  <= 1'b0;
      epoch_pulse <= 1'b0;
      bit_pulse   <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      if (chip_en) begin
        chip_cnt   <= (chip_cnt == LAST_CHIP) ? '0 : chip_cnt + 1'b1;
        spread_out <= (state == RUN) ? (code_in ^ cur_bit) : 1'b0;
      end
      epoch_pulse <= epoch_end;
      bit_pulse   <= bit_end;
      if (underrun_set) underrun <= 1'b1;
    end
  end

endmodule

// File: doc/ca_spreader.md
CA_SPREADER -- requirements
Module: ca_spreader

Interface
REQ-001 SHALL have parameter CHIPS_PER_EPOCH, default 1023: chips per code epoch, legal range 2..1023.
REQ-002 SHALL have parameter EPOCHS_PER_BIT, default 20: code epochs per data bit, legal range 1..63.
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port chip_en, input, 1: chip strobe, one clk pulse per chip.
REQ-006 SHALL have port code_in, input, 1: C/A chip from the PN generator, valid when chip_en=1.
REQ-007 SHALL have port data_in, input, 1: navigation data bit.
REQ-008 SHALL have port data_valid, input, 1: data_in is offered.
REQ-009 SHALL have port data_ready, output, 1: block accepts data_in this cycle.
REQ-010 SHALL have port spread_out, output, 1: registered spread chip.
REQ-011 SHALL have port epoch_pulse, output, 1: one-cycle pulse after the last chip of each epoch.
REQ-012 SHALL have port bit_pulse, output, 1: one-cycle pulse after the last chip of each data bit in RUN.
REQ-013 SHALL have port underrun, output, 1: sticky flag, set when a bit boundary finds no next bit.

Function
REQ-014 SHALL hold a current-bit register cur_bit and a one-entry holding buffer, next_bit plus next_full.
REQ-015 SHALL drive data_ready = !next_full combinationally, with no dependence on data_valid.
REQ-016 SHALL accept on data_valid && data_ready: next_bit <= data_in and next_full <= 1.
REQ-017 SHALL run chip_cnt (width clog2(CHIPS_PER_EPOCH)) from reset release in IDLE and RUN alike.
- chip_cnt SHALL increment only on chip_en.
- chip_cnt SHALL wrap from CHIPS_PER_EPOCH-1 to 0.
REQ-018 SHALL define epoch_end = chip_en && chip_cnt==CHIPS_PER_EPOCH-1, and assert epoch_pulse the cycle after epoch_end.
REQ-019 SHALL implement state machine states IDLE and RUN.
REQ-020 In IDLE, on epoch_end with next_full=1, SHALL make these updates in one edge:
- cur_bit <= next_bit, next_full <= 0
- epoch_cnt <= 0
- state <= RUN
REQ-021 In IDLE, epoch_cnt SHALL hold 0.
REQ-022 In RUN, on epoch_end with epoch_cnt < EPOCHS_PER_BIT-1, SHALL increment epoch_cnt.
REQ-023 In RUN, on epoch_end with epoch_cnt==EPOCHS_PER_BIT-1, SHALL assert bit_pulse the next cycle and set epoch_cnt <= 0.
- With next_full=1: SHALL load cur_bit <= next_bit, clear next_full and stay in RUN.
- With next_full=0: SHALL go to IDLE and set underrun.
REQ-024 On chip_en, spread_out SHALL update to code_in XOR cur_bit in RUN and to 0 in IDLE.
- The state used is the state before the edge, so the boundary chip carries the old bit.
- spread_out SHALL hold its value between chip_en strobes.
REQ-025 New bits SHALL take effect from the chip with chip_cnt==0 that follows an epoch_end, so bit edges stay aligned to code epochs.
REQ-026 Accept and load SHALL never coincide, since accept needs next_full=0 and load needs next_full=1.
REQ-027 chip_en asserted on consecutive cycles SHALL be legal, with each strobe counted.

Reset
REQ-028 On rst=1, asynchronously, SHALL clear these and hold them while rst=1:
- chip_cnt, epoch_cnt, cur_bit, next_bit, next_full = 0
- state = IDLE
- spread_out, epoch_pulse, bit_pulse, underrun = 0
REQ-029 SHALL drive data_ready=1 during and immediately after reset.
REQ-030 Reset asserted mid-bit or mid-epoch SHALL discard the buffered bit and any partial epoch and bit counts.
REQ-031 underrun SHALL clear only on reset.

Verification (CHIPS_PER_EPOCH=7, EPOCHS_PER_BIT=2, chip_en every cycle unless stated)
REQ-032 Reset release, no data offered -> spread_out=0 throughout, epoch_pulse every 7 cycles, bit_pulse never, underrun=0, data_ready=1.
REQ-033 Offer data_in=1 at cycle 2 -> data_ready drops the next cycle; from the next chip_cnt==0, spread_out = !code_in for 14 chips.
- Then bit_pulse fires, state returns to IDLE and underrun=1.
REQ-034 Offer bits 1,0 back-to-back, each taken when data_ready=1 -> 14 chips of !code_in, then 14 chips of code_in.
- bit_pulse fires after each bit; underrun stays 0 until the second bit ends.
REQ-035 chip_en one cycle in three, with code_in=1 constant and data bit 0 -> spread_out=1 and changes only on chip_en cycles; epoch_pulse spacing is 21 cycles.
REQ-036 Assert rst at chip 4 of epoch 1 while next_full=1 -> all outputs 0 and data_ready=1 at once.
- After release, chip_cnt restarts at 0 and the old buffered bit is never output.
REQ-037 Hold data_valid=1 continuously with alternating data -> exactly one accept per loaded bit, no bit lost or duplicated over 10 bits, underrun=0.
